// File: rtl/result_collector.sv
// Captures each rising edge of the FSM result strobe into a small FIFO and streams entries out as two 16-bit halves.
// Build option: define RCOL_SKIP_ERR_EN to discard results whose error code is non-zero.
module result_collector #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r_i,
  input  logic [31:0]   data_in,
  input  logic [1:0]    err_in,
  input  logic          rd,
  output logic [15:0]   data_out,
  output logic [1:0]    err_out,
  output logic          half,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  typedef enum logic {HI = 1'b0, LO = 1'b1} half_state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  half_state_e state_q, state_d;
  logic [33:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          r_prev_q;
  logic          overflow_q, overflow_d;

  logic push_req, push_ok, do_push, transfer, pop;
  logic [33:0] head;

  assign push_req = r_i & ~r_prev_q;
`ifdef RCOL_SKIP_ERR_EN
  assign push_ok  = push_req & (err_in == 2'b00);
`else
  assign push_ok  = push_req;
`endif

  assign valid    = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign half     = (state_q == LO);
  assign overflow = overflow_q;

  assign transfer = valid & rd;
  assign pop      = transfer & (state_q == LO);
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign do_push  = push_ok & (~full | pop);

  assign head     = mem_q[rptr_q];
  assign data_out = valid ? (half ? head[15:0] : head[31:16]) : 16'h0000;
  assign err_out  = valid ? head[33:32] : 2'b00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      HI: if (transfer) state_d = LO;
      LO: if (transfer) state_d = HI;
      default: state_d = HI;
    endcase
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + ONE_C;
    else if (!do_push && pop) count_d = count_q - ONE_C;
    if (push_ok && !do_push)  overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HI;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      r_prev_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      r_prev_q   <= r_i;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; its contents are only observable through valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= {err_in, data_in};
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream capture stage for the iterative float FSM: watches the FSM's `r_o` result strobe, snapshots the 32-bit `dataOut` together with the 2-bit `err` code on every new result, and buffers the pairs in a small FIFO. Buffered results are streamed out as two 16-bit halves, high half first, over a valid/ready handshake. This gives the FSM's 16-bit upstream host a way to read back results at the same word width it uses for loading.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `AW`, 2: pointer width, equal to log2(DEPTH).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `r_i` in 1: FSM `r_o`. It is a level that may stay high for several cycles; only its rising edge marks a new result.
- `data_in` in 32: FSM `dataOut`.
- `err_in` in 2: FSM `err`.
- `rd` in 1: consumer ready.
- `data_out` out 16: current half-word.
- `err_out` out 2: error code of the head entry.
- `half` out 1: 0 = bits [31:16], 1 = bits [15:0].
- `valid` out 1: head entry is available.
- `full` out 1: count == DEPTH.
- `count` out AW+1: number of stored entries.
- `overflow` out 1: sticky; a result was lost.

## Operation
- **Edge detect.** `r_prev` is a register that follows `r_i`. `push_req = r_i & ~r_prev`.
- **Push.** When `push_req` is high, write `{err_in, data_in}` at `wptr` and increment `wptr` (wraps modulo DEPTH).
  - If full and no pop in the same cycle: the entry is dropped, `overflow` is set to 1, and pointers and count are unchanged.
- **Output.**
  - `valid = (count != 0)`.
  - `data_out` = head[31:16] when `half==0`, head[15:0] when `half==1`.
  - `err_out` = head err, held for both halves.
- **Transfer.** A transfer occurs on a cycle where `valid & rd` is high.
  - If `half==0`: set `half` to 1.
  - If `half==1`: set `half` to 0 and pop (increment `rptr`, wraps).
- **Simultaneous push and pop.** Both take effect and `count` is unchanged. This is accepted even when full, because the pop frees the slot in the same cycle.
- **Count.** `count` +1 on push only, −1 on pop only.
- **Empty.** `rd` has no effect and `half` stays 0.
- **State machine for `half`.** Two states:
  - HI→LO on transfer.
  - LO→HI on transfer, with pop.
  - No other transitions.
- **Data path.** No arithmetic on the data; it is stored bit-exact.
- **Reset (`reset==0`, any time, including mid-transfer).** `wptr=rptr=0`, `count=0`, `half=0`, `r_prev=0`, `overflow=0`. Stored data becomes don't-care.
  - If `r_i` is already high when reset is released, that counts as a rising edge on the first clock.

## Timing
- Reset values of the outputs: `valid=0`, `full=0`, `count=0`, `half=0`, `overflow=0`, `err_out=0`, `data_out=0`.
  - `data_out` and `err_out` must be gated to 0 when the FIFO is empty.
- **Latency.** `r_i` is sampled high at edge N with `r_prev==0`. The entry is written at edge N, and `valid` is high after edge N (visible in cycle N+1).
- **Throughput.** One half-word per cycle while `rd` stays high. A full entry takes 2 cycles.
- **Output timing.** `valid`, `full`, `count` and `half` are combinational from registers only. There is no combinational path from `rd` to `valid`.
- **Hold rule.** `data_out` and `err_out` stay stable while `valid & ~rd`.
- **Minimum result spacing.** Consecutive results need `r_i` low for at least 1 cycle between them (the FSM guarantees this via its counter state).

## Configuration
- **`RCOL_SKIP_ERR_EN` defined:** a push with `err_in != 0` is discarded.
  - No write, pointers and count unchanged, `overflow` unaffected.
  - Only error-free results are buffered.
  - `err_out` then reads 0 for every valid head entry.
- **`RCOL_SKIP_ERR_EN` undefined:** every rising edge is stored together with its error code.

## Test plan
- **Single result.** Reset, then `r_i` rising with `data_in=32'h40490FDB`, `err_in=0`, and `rd=1`.
  - Required: `valid` goes high one cycle later; `data_out=16'h4049` with `half=0`, then `16'h0FDB` with `half=1`; then `valid=0`, `count=0`.
- **Level hold.** Hold `r_i` high for 5 cycles with `rd=0`.
  - Required: `count=1` (exactly one entry stored).
- **Overflow.** Send 5 rising edges (data 1..5) with `rd=0`, DEPTH=4.
  - Required: `full=1`, `count=4`, `overflow=1`.
  - Then drain with `rd=1`: output words are 0,1,0,2,0,3,0,4, and `overflow` stays 1.
- **Full with pop.** FIFO full, `half=1`, `rd=1`, and a rising edge in the same cycle.
  - Required: `count` stays 4, `overflow=0`, and the new entry appears last on drain.
- **Error tagging.** Push with `err_in=2'b10`, `data_in=0`.
  - Without `RCOL_SKIP_ERR_EN`: `err_out=2'b10` for both halves.
  - With `RCOL_SKIP_ERR_EN`: `count` stays 0.
- **Async reset mid-transfer.** After the high half has transferred (`half=1`, `count=2`), assert `reset` low between clock edges.
  - Required: `valid`, `count` and `half` go to 0 immediately (no clock edge needed).
  - After release, a fresh push reads its high half first.
